// File: rtl/sine_ctrl_pkg.sv
// Shared types for the sine_wave generator and its sweep controller.
package sine_ctrl_pkg;

  localparam int unsigned PHASE_SIZE = 8;
  localparam int unsigned TABLE_SIZE = 56;
  localparam int unsigned PHASE_W    = PHASE_SIZE + 1;
  localparam int unsigned WIDE_W     = PHASE_SIZE + 2;

  typedef logic signed [PHASE_SIZE:0] phase_t;
  typedef logic signed [WIDE_W-1:0]   wide_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_DWELL,
    ST_STEP,
    ST_FINISH
  } sweep_state_t;

  // Move cur by inc toward lim, clamping at lim; widened so cur+inc cannot wrap.
  function automatic phase_t step_toward(phase_t cur, phase_t inc, phase_t lim, logic down);
    wide_t nxt;
    if (down) begin
      nxt = WIDE_W'(cur) - WIDE_W'(inc);
      if (nxt < WIDE_W'(lim)) nxt = WIDE_W'(lim);
    end else begin
      nxt = WIDE_W'(cur) + WIDE_W'(inc);
      if (nxt > WIDE_W'(lim)) nxt = WIDE_W'(lim);
    end
    return PHASE_W'(nxt);
  endfunction

endpackage

// File: rtl/sweep_dwell_counter.sv
// Per-step dwell down-counter: loads max(dwell,1)-1, decrements to zero and holds there.
module sweep_dwell_counter #(
  parameter int unsigned DWELL_W = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               load,
  input  logic               dec,
  input  logic [DWELL_W-1:0] dwell,
  output logic               zero_c
);

  logic [DWELL_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - DWELL_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/sine_sweep_controller.sv
// Steps sine_wave's phaseStep from start to end with a programmable dwell per step.
// Define SINE_SWEEP_BIDIR_EN to sweep back down to the start step after reaching the end.
module sine_sweep_controller
  import sine_ctrl_pkg::*;
#(
  parameter int unsigned DWELL_W       = 16,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  phase_t             cfg_phase,
  input  phase_t             cfg_step_start,
  input  phase_t             cfg_step_end,
  input  phase_t             cfg_step_inc,
  input  logic [DWELL_W-1:0] cfg_dwell,
  output phase_t             gen_phase,
  output phase_t             gen_phase_step,
  output logic               gen_reset,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic [7:0]         step_idx
);

  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  sweep_state_t       state_q, state_d;
  phase_t             gen_phase_q, gen_phase_d;
  phase_t             step_q, step_d;
  logic               gen_reset_q, gen_reset_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cfg_err_q, cfg_err_d;
  logic [7:0]         step_idx_q, step_idx_d;
  phase_t             lat_start_q, lat_start_d;
  phase_t             lat_end_q, lat_end_d;
  phase_t             lat_inc_q, lat_inc_d;
  logic [DWELL_W-1:0] lat_dwell_q, lat_dwell_d;
  logic               dir_dn_q, dir_dn_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic               cnt_load_c, cnt_dec_c, cnt_zero_c;
  logic               cfg_bad_c;
  logic [7:0]         idx_inc_c;

  sweep_dwell_counter #(.DWELL_W(DWELL_W)) u_dwell (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (cnt_load_c),
    .dec     (cnt_dec_c),
    .dwell   (lat_dwell_q),
    .zero_c  (cnt_zero_c)
  );

  assign cfg_bad_c = (cfg_step_start < phase_t'(1)) || (cfg_step_end < cfg_step_start) ||
                     (cfg_step_inc < phase_t'(0));
  assign idx_inc_c = (step_idx_q == 8'hFF) ? step_idx_q : step_idx_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    gen_phase_d = gen_phase_q;
    step_d      = step_q;
    cfg_err_d   = 1'b0;
    step_idx_d  = step_idx_q;
    lat_start_d = lat_start_q;
    lat_end_d   = lat_end_q;
    lat_inc_d   = lat_inc_q;
    lat_dwell_d = lat_dwell_q;
    dir_dn_d    = dir_dn_q;
    settle_d    = settle_q;
    cnt_load_c  = 1'b0;
    cnt_dec_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          if (cfg_bad_c) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d     = ST_LOAD;
            gen_phase_d = cfg_phase;
            step_d      = cfg_step_start;
            step_idx_d  = 8'd0;
            lat_start_d = cfg_step_start;
            lat_end_d   = cfg_step_end;
            lat_inc_d   = cfg_step_inc;
            lat_dwell_d = cfg_dwell;
            dir_dn_d    = 1'b0;
          end
        end
      end
      ST_LOAD: begin
        state_d  = ST_SETTLE;
        settle_d = SET_W'(SETTLE_CYCLES - 1);
      end
      ST_SETTLE: begin
        if (settle_q == '0) begin
          state_d    = ST_DWELL;
          cnt_load_c = 1'b1;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end
      ST_DWELL: begin
        if (!cnt_zero_c) begin
          cnt_dec_c = 1'b1;
        end else if (dir_dn_q) begin
          if (step_q == lat_start_q) begin
            state_d = ST_FINISH;
          end else begin
            state_d    = ST_STEP;
            step_d     = step_toward(step_q, lat_inc_q, lat_start_q, 1'b1);
            step_idx_d = idx_inc_c;
          end
        end else if ((step_q == lat_end_q) || (lat_inc_q == '0)) begin
`ifdef SINE_SWEEP_BIDIR_EN
          if ((lat_inc_q != '0) && (lat_end_q != lat_start_q)) begin
            state_d    = ST_STEP;
            dir_dn_d   = 1'b1;
            step_d     = step_toward(step_q, lat_inc_q, lat_start_q, 1'b1);
            step_idx_d = idx_inc_c;
          end else begin
            state_d = ST_FINISH;
          end
`else
          state_d = ST_FINISH;
`endif
        end else begin
          state_d    = ST_STEP;
          step_d     = step_toward(step_q, lat_inc_q, lat_end_q, 1'b0);
          step_idx_d = idx_inc_c;
        end
      end
      ST_STEP: begin
        state_d    = ST_DWELL;
        cnt_load_c = 1'b1;
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        step_d  = '0;
      end
      default: begin
        state_d = ST_IDLE;
        step_d  = '0;
      end
    endcase

    // Abort freezes the generator and drops back to IDLE without a done pulse.
    if (abort && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      step_d     = '0;
      step_idx_d = step_idx_q;
      cnt_load_c = 1'b0;
    end

    gen_reset_d = (state_d == ST_LOAD);
    done_d      = (state_d == ST_FINISH);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      gen_phase_q <= '0;
      step_q      <= '0;
      gen_reset_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      step_idx_q  <= 8'd0;
      lat_start_q <= '0;
      lat_end_q   <= '0;
      lat_inc_q   <= '0;
      lat_dwell_q <= '0;
      dir_dn_q    <= 1'b0;
      settle_q    <= '0;
    end else begin
      state_q     <= state_d;
      gen_phase_q <= gen_phase_d;
      step_q      <= step_d;
      gen_reset_q <= gen_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
      step_idx_q  <= step_idx_d;
      lat_start_q <= lat_start_d;
      lat_end_q   <= lat_end_d;
      lat_inc_q   <= lat_inc_d;
      lat_dwell_q <= lat_dwell_d;
      dir_dn_q    <= dir_dn_d;
      settle_q    <= settle_d;
    end
  end

  assign gen_phase      = gen_phase_q;
  assign gen_phase_step = step_q;
  assign gen_reset      = gen_reset_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign cfg_err        = cfg_err_q;
  assign step_idx       = step_idx_q;

endmodule

// File: tb/tb_sine_sweep_controller.sv
// Bench for sine_sweep_controller: per-cycle trace model built from the sweep's step list.
module tb_sine_sweep_controller;
  import sine_ctrl_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned SC = 2;

  logic          clock = 1'b0;
  logic          reset_n, start, abort;
  phase_t        cfg_phase, cfg_step_start, cfg_step_end, cfg_step_inc;
  logic [DW-1:0] cfg_dwell;
  phase_t        gen_phase, gen_phase_step;
  logic          gen_reset, busy, done, cfg_err;
  logic [7:0]    step_idx;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int step;
    bit rst;
    bit dn;
    bit by;
    int idx;
  } exp_t;
  exp_t exp_q[$];

  sine_sweep_controller #(.DWELL_W(DW), .SETTLE_CYCLES(SC)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .abort          (abort),
    .cfg_phase      (cfg_phase),
    .cfg_step_start (cfg_step_start),
    .cfg_step_end   (cfg_step_end),
    .cfg_step_inc   (cfg_step_inc),
    .cfg_dwell      (cfg_dwell),
    .gen_phase      (gen_phase),
    .gen_phase_step (gen_phase_step),
    .gen_reset      (gen_reset),
    .busy           (busy),
    .done           (done),
    .cfg_err        (cfg_err),
    .step_idx       (step_idx)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected outputs, one entry per cycle starting the cycle after start is accepted.
  task automatic build(input int s, input int e, input int inc, input int dw);
    int vals[$];
    int v;
    int d;
    exp_t x;
    d = (dw == 0) ? 1 : dw;
    v = s;
    vals.push_back(v);
    while (inc != 0 && v != e) begin
      v = (v + inc > e) ? e : v + inc;
      vals.push_back(v);
    end
`ifdef SINE_SWEEP_BIDIR_EN
    if (inc != 0 && e != s) begin
      while (v != s) begin
        v = (v - inc < s) ? s : v - inc;
        vals.push_back(v);
      end
    end
`endif
    exp_q.delete();
    x = '{step: s, rst: 1'b1, dn: 1'b0, by: 1'b1, idx: 0};
    exp_q.push_back(x);
    for (int i = 0; i < int'(SC); i++) begin
      x = '{step: s, rst: 1'b0, dn: 1'b0, by: 1'b1, idx: 0};
      exp_q.push_back(x);
    end
    for (int i = 0; i < vals.size(); i++) begin
      x = '{step: vals[i], rst: 1'b0, dn: 1'b0, by: 1'b1, idx: (i > 255) ? 255 : i};
      if (i > 0) exp_q.push_back(x);
      for (int j = 0; j < d; j++) exp_q.push_back(x);
    end
    x.dn = 1'b1;
    exp_q.push_back(x);
    x = '{step: 0, rst: 1'b0, dn: 1'b0, by: 1'b0, idx: x.idx};
    exp_q.push_back(x);
  endtask

  // Runs one sweep from the current cycle; abort_at >= 0 aborts while in that trace entry.
  task automatic run_sweep(input int ph, input int s, input int e, input int inc, input int dw,
                           input int abort_at, input bit scramble, input string name);
    exp_t x;
    build(s, e, inc, dw);
    cfg_phase      = phase_t'(ph);
    cfg_step_start = phase_t'(s);
    cfg_step_end   = phase_t'(e);
    cfg_step_inc   = phase_t'(inc);
    cfg_dwell      = DW'(dw);
    start          = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      x = exp_q[k];
      if (scramble) begin
        cfg_phase      = phase_t'($urandom);
        cfg_step_start = phase_t'($urandom);
        cfg_step_end   = phase_t'($urandom);
        cfg_step_inc   = phase_t'($urandom);
        cfg_dwell      = DW'($urandom);
        start          = (k < exp_q.size() - 1) ? 1'($urandom) : 1'b0;
      end
      total++;
      if (gen_phase_step !== phase_t'(x.step)) begin
        bad++;
        $display("FAIL %s step cyc=%0d got=%0d want=%0d", name, k, gen_phase_step, x.step);
      end
      total++;
      if (gen_reset !== x.rst) begin
        bad++;
        $display("FAIL %s gen_reset cyc=%0d got=%b want=%b", name, k, gen_reset, x.rst);
      end
      total++;
      if (done !== x.dn) begin
        bad++;
        $display("FAIL %s done cyc=%0d got=%b want=%b", name, k, done, x.dn);
      end
      total++;
      if (busy !== x.by) begin
        bad++;
        $display("FAIL %s busy cyc=%0d got=%b want=%b", name, k, busy, x.by);
      end
      total++;
      if (step_idx !== 8'(x.idx)) begin
        bad++;
        $display("FAIL %s step_idx cyc=%0d got=%0d want=%0d", name, k, step_idx, x.idx);
      end
      total++;
      if (gen_phase !== phase_t'(ph) || cfg_err !== 1'b0) begin
        bad++;
        $display("FAIL %s phase/err cyc=%0d got=%0d/%b want=%0d/0", name, k, gen_phase, cfg_err, ph);
      end
      if (k == abort_at) begin
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if (busy !== 1'b0 || gen_phase_step !== phase_t'(0) || done !== 1'b0) begin
          bad++;
          $display("FAIL %s abort got busy=%b step=%0d done=%b want 0/0/0", name, busy, gen_phase_step, done);
        end
        return;
      end
      if (k < exp_q.size() - 1) tick();
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b1;
    abort = 1'b0;
    cfg_phase = phase_t'(10);
    cfg_step_start = phase_t'(1);
    cfg_step_end = phase_t'(4);
    cfg_step_inc = phase_t'(1);
    cfg_dwell = DW'(3);
    repeat (3) tick();
    total++;
    if ({gen_phase, gen_phase_step, gen_reset, busy, done, cfg_err, step_idx} !== '0) begin
      bad++;
      $display("FAIL reset_state got step=%0d busy=%b rst=%b want all 0", gen_phase_step, busy, gen_reset);
    end
    start = 1'b0;
    reset_n = 1'b1;
    tick();
    total++;
    if (busy !== 1'b0 || gen_reset !== 1'b0) begin
      bad++;
      $display("FAIL reset_release got busy=%b rst=%b want 0/0", busy, gen_reset);
    end
  endtask

  task automatic test_spec_examples();
    run_sweep(0, 1, 4, 1, 3, -1, 1'b0, "ramp_1_4");
    run_sweep(45, 2, 7, 4, 2, -1, 1'b0, "sat_2_7");
    run_sweep(-90, 3, 3, 5, 1, -1, 1'b0, "single_eq");
    run_sweep(180, 2, 9, 0, 2, -1, 1'b0, "inc_zero");
    run_sweep(-180, 1, 5, 2, 0, -1, 1'b0, "dwell_zero");
    run_sweep(7, 1, 255, 200, 1, -1, 1'b0, "wide_sat");
    run_sweep(3, 1, 255, 1, 0, -1, 1'b0, "idx_long");
  endtask

  task automatic test_cfg_err();
    int bs[3] = '{5, 0, 2};
    int be[3] = '{3, 4, 6};
    int bi[3] = '{1, 1, -1};
    for (int i = 0; i < 3; i++) begin
      cfg_step_start = phase_t'(bs[i]);
      cfg_step_end = phase_t'(be[i]);
      cfg_step_inc = phase_t'(bi[i]);
      start = 1'b1;
      tick();
      start = 1'b0;
      total++;
      if (cfg_err !== 1'b1 || busy !== 1'b0 || gen_reset !== 1'b0) begin
        bad++;
        $display("FAIL cfg_err_pulse case=%0d got err=%b busy=%b rst=%b want 1/0/0", i, cfg_err, busy, gen_reset);
      end
      tick();
      total++;
      if (cfg_err !== 1'b0 || busy !== 1'b0 || gen_reset !== 1'b0) begin
        bad++;
        $display("FAIL cfg_err_clear case=%0d got err=%b busy=%b rst=%b want 0/0/0", i, cfg_err, busy, gen_reset);
      end
    end
  endtask

  task automatic test_start_abort_idle();
    cfg_step_start = phase_t'(1);
    cfg_step_end = phase_t'(3);
    cfg_step_inc = phase_t'(1);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || gen_reset !== 1'b0 || cfg_err !== 1'b0) begin
      bad++;
      $display("FAIL start_abort_idle got busy=%b rst=%b err=%b want 0/0/0", busy, gen_reset, cfg_err);
    end
    tick();
  endtask

  task automatic test_abort_and_restart();
    // Entry SC+3+2 lies inside the second dwell of a dwell=3 sweep.
    run_sweep(20, 1, 4, 1, 3, int'(SC) + 5, 1'b0, "abort_dwell2");
    run_sweep(30, 2, 5, 1, 1, -1, 1'b0, "restart");
  endtask

  task automatic test_reset_mid_sweep();
    cfg_phase = phase_t'(50);
    cfg_step_start = phase_t'(1);
    cfg_step_end = phase_t'(4);
    cfg_step_inc = phase_t'(1);
    cfg_dwell = DW'(3);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    reset_n = 1'b0;
    start = 1'b1;
    tick();
    total++;
    if ({gen_phase, gen_phase_step, gen_reset, busy, done, cfg_err, step_idx} !== '0) begin
      bad++;
      $display("FAIL reset_mid got phase=%0d step=%0d busy=%b idx=%0d want all 0", gen_phase, gen_phase_step, busy, step_idx);
    end
    reset_n = 1'b1;
    start = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0 || gen_reset !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_idle got busy=%b rst=%b want 0/0", busy, gen_reset);
    end
  endtask

  task automatic test_random_sweeps();
    int s, e, inc, dw, ph;
    for (int n = 0; n < 24; n++) begin
      s   = int'($urandom_range(1, 30));
      e   = s + int'($urandom_range(0, 60));
      inc = int'($urandom_range(0, 20));
      dw  = int'($urandom_range(0, 4));
      ph  = int'($urandom_range(0, 360)) - 180;
      run_sweep(ph, s, e, inc, dw, -1, 1'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_spec_examples();
    test_cfg_err();
    test_start_abort_idle();
    test_abort_and_restart();
    test_reset_mid_sweep();
    test_random_sweeps();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
